// File: rtl/apb_reg_slave.sv
// APB completer register bank: register 0 is a read-only ID, registers 1..NUM_REGS-1 are read/write.
// Optional protocol checker enabled by defining APB_SLV_PROTOCOL_CHECK_EN.
module apb_reg_slave #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'h5A1F_0001
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          paddr,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [DATA_W-1:0]          pwdata,
    output logic [DATA_W-1:0]          prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       proto_err
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_err;
    logic               r_write;
    logic [DATA_W-1:0]  r_prdata;
    logic [DATA_W-1:0]  r_regs [1:NUM_REGS-1];

    logic [DATA_W-1:0]  w_reg_arr [NUM_REGS];
    logic [ADDR_W-3:0]  w_addr_idx;
    logic [IDX_W-1:0]   w_idx;
    logic               w_dec_err;
    logic               w_setup;
    logic               w_complete;
    logic               w_abort;
    logic               w_cnt_zero;

    assign w_addr_idx = paddr[ADDR_W-1:2];
    assign w_idx      = w_addr_idx[IDX_W-1:0];
    assign w_dec_err  = (paddr[1:0] != 2'b00)
                      | (w_addr_idx >= (ADDR_W-2)'(NUM_REGS))
                      | (pwrite & (w_addr_idx == {(ADDR_W-2){1'b0}}));
    assign w_cnt_zero = (r_cnt == {CNT_W{1'b0}});
    assign w_setup    = (r_state == ST_IDLE) & psel & ~penable;
    assign w_complete = (r_state == ST_ACCESS) & psel & penable & w_cnt_zero;
    assign w_abort    = (r_state == ST_ACCESS) & ~psel;

    // Unified register view: slot 0 is the hard-wired ID
    always_comb begin
        w_reg_arr[0] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_reg_arr[i] = r_regs[i];
        end
    end

    // Parallel export of every register
    always_comb begin
        regs_out = {(NUM_REGS*DATA_W){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_W +: DATA_W] = w_reg_arr[i];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; psel dropping in ACCESS aborts the transfer
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_next_state = ST_ACCESS;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (w_abort || w_complete) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ACCESS;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs depend only on state and the decode latched at setup
    always_comb begin
        prdata = r_prdata;
        if ((r_state == ST_ACCESS) && w_cnt_zero) begin
            pready  = 1'b1;
            pslverr = r_err;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
        end
    end

    // Setup-phase decode capture, wait counter and read-data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_idx    <= {IDX_W{1'b0}};
            r_err    <= 1'b0;
            r_write  <= 1'b0;
            r_prdata <= {DATA_W{1'b0}};
        end else if (w_setup) begin
            r_cnt    <= CNT_LOAD;
            r_idx    <= w_idx;
            r_err    <= w_dec_err;
            r_write  <= pwrite;
            r_prdata <= (!w_dec_err && !pwrite) ? w_reg_arr[w_idx] : {DATA_W{1'b0}};
        end else if (w_complete || w_abort) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_prdata <= {DATA_W{1'b0}};
        end else if ((r_state == ST_ACCESS) && psel && penable && !w_cnt_zero) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Register file write on a legal completing write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (w_complete && r_write && !r_err) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_regs[i] <= pwdata;
                end
            end
        end
    end

`ifdef APB_SLV_PROTOCOL_CHECK_EN
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_proto_err;
    logic              w_proto_viol;

    assign w_proto_viol = ((r_state == ST_IDLE) & penable)
                        | ((r_state == ST_ACCESS) & psel &
                           ((paddr != r_paddr) | (pwrite != r_write) | (pwdata != r_pwdata)))
                        | w_abort;

    // Reference copy of the setup-phase bus and the sticky violation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_paddr     <= {ADDR_W{1'b0}};
            r_pwdata    <= {DATA_W{1'b0}};
            r_proto_err <= 1'b0;
        end else begin
            if (w_setup) begin
                r_paddr  <= paddr;
                r_pwdata <= pwdata;
            end else begin
                r_paddr  <= r_paddr;
                r_pwdata <= r_pwdata;
            end
            r_proto_err <= r_proto_err | w_proto_viol;
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one instance with one wait state, one zero-wait instance.
module tb_apb_reg_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;
    localparam logic [31:0] ID = 32'h5A1F_0001;
`ifdef APB_SLV_PROTOCOL_CHECK_EN
    localparam logic [31:0] PE = 32'd1;
`else
    localparam logic [31:0] PE = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          psel_a, penable_a, psel_b, penable_b;
    logic [DW-1:0] prdata_a, prdata_b;
    logic          pready_a, pready_b, pslverr_a, pslverr_b, proto_a, proto_b;
    logic [NR*DW-1:0] regs_a, regs_b;

    always #5 clk = ~clk;

    apb_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_CYCLES(1), .ID_VALUE(ID)) u_dut (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel_a), .penable(penable_a),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
        .pslverr(pslverr_a), .regs_out(regs_a), .proto_err(proto_a));

    apb_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel_b), .penable(penable_b),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
        .pslverr(pslverr_b), .regs_out(regs_b), .proto_err(proto_b));

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [13];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] t_rd;
    logic        t_err;
    int          t_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_bus(input int sel, input logic s, input logic e);
        if (sel == 0) begin
            psel_a = s; penable_a = e;
        end else begin
            psel_b = s; penable_b = e;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the completion edge with the bus idle.
    task automatic xfer(input int sel, input logic [31:0] a, input logic w, input logic [31:0] d,
                        output logic [31:0] rd, output logic err, output int cyc);
        logic done;
        logic rdy, perr;
        logic [31:0] pd;
        paddr = a; pwrite = w; pwdata = d;
        set_bus(sel, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_bus(sel, 1'b1, 1'b1);
        cyc = 0; rd = 32'h0; err = 1'b0; done = 1'b0;
        while (!done && cyc < 16) begin
            @(negedge clk);
            cyc++;
            rdy  = (sel == 0) ? pready_a  : pready_b;
            perr = (sel == 0) ? pslverr_a : pslverr_b;
            pd   = (sel == 0) ? prdata_a  : prdata_b;
            if (rdy) begin
                rd = pd; err = perr; done = 1'b1;
            end else begin
                chk("pslverr_while_waiting", 32'(perr), 32'h0);
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout: got no pready after %0d cycles, expected completion", cyc);
        end
        set_bus(sel, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{32'h04, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{32'h04, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{32'h00, 1'b0, 32'h0,         32'h5A1F_0001, 1'b0};
        vecs[3]  = '{32'h00, 1'b1, 32'h0,         32'h0,         1'b1};
        vecs[4]  = '{32'h00, 1'b0, 32'h0,         32'h5A1F_0001, 1'b0};
        vecs[5]  = '{32'h20, 1'b0, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{32'h06, 1'b1, 32'h1234_5678, 32'h0,         1'b1};
        vecs[7]  = '{32'h04, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{32'h1C, 1'b1, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[9]  = '{32'h1C, 1'b0, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[10] = '{32'h08, 1'b0, 32'h0,         32'h0,         1'b0};
        vecs[11] = '{32'h24, 1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[12] = '{32'h02, 1'b0, 32'h0,         32'h0,         1'b1};

        rst_n = 1'b0; paddr = 32'h0; pwrite = 1'b0; pwdata = 32'h0;
        psel_a = 1'b0; penable_a = 1'b0; psel_b = 1'b0; penable_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prdata",  prdata_a, 32'h0);
        chk("rst_pready",  32'(pready_a), 32'h0);
        chk("rst_pslverr", 32'(pslverr_a), 32'h0);
        chk("rst_proto",   32'(proto_a), 32'h0);
        chk("rst_reg1",    regs_a[63:32], 32'h0);
        chk("rst_reg0",    regs_a[31:0], ID);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            xfer(0, vecs[i].addr, vecs[i].wr, vecs[i].wdata, t_rd, t_err, t_cyc);
            chk($sformatf("vec%0d_prdata", i), t_rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_pslverr", i), 32'(t_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_cycles", i), 32'(t_cyc), 32'd2);
        end
        @(negedge clk);
        chk("regs_out_reg0", regs_a[31:0],    ID);
        chk("regs_out_reg1", regs_a[63:32],   32'hDEAD_BEEF);
        chk("regs_out_reg2", regs_a[95:64],   32'h0);
        chk("regs_out_reg7", regs_a[255:224], 32'hA5A5_A5A5);
        chk("proto_clean",   32'(proto_a), 32'h0);
        @(posedge clk); #1;

        // Zero-wait instance, back-to-back write then read
        xfer(1, 32'h08, 1'b1, 32'h1, t_rd, t_err, t_cyc);
        chk("w0_write_cycles", 32'(t_cyc), 32'd1);
        chk("w0_write_err",    32'(t_err), 32'h0);
        xfer(1, 32'h08, 1'b0, 32'h0, t_rd, t_err, t_cyc);
        chk("w0_read_cycles",  32'(t_cyc), 32'd1);
        chk("w0_read_data",    t_rd, 32'h1);
        chk("w0_regs_out",     regs_b[95:64], 32'h1);

        // Abort: psel dropped during ACCESS of write 0x10
        paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hFFFF;
        psel_a = 1'b1; penable_a = 1'b0;
        @(posedge clk); #1;
        penable_a = 1'b1;
        @(negedge clk);
        chk("abort_pready_wait", 32'(pready_a), 32'h0);
        @(posedge clk); #1;
        psel_a = 1'b0; penable_a = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_reg4",   regs_a[159:128], 32'h0);
        chk("abort_pready", 32'(pready_a), 32'h0);
        chk("abort_proto",  32'(proto_a), PE);
        @(posedge clk); #1;

        // Reset asserted while pready=1 on a write, before the completion edge
        paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h1234;
        psel_a = 1'b1; penable_a = 1'b0;
        @(posedge clk); #1;
        penable_a = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid_pready_before", 32'(pready_a), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_pready",  32'(pready_a), 32'h0);
        chk("rstmid_pslverr", 32'(pslverr_a), 32'h0);
        chk("rstmid_proto",   32'(proto_a), 32'h0);
        psel_a = 1'b0; penable_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 32'h0C, 1'b0, 32'h0, t_rd, t_err, t_cyc);
        chk("rstmid_read_reg3", t_rd, 32'h0);
        chk("rstmid_regs_reg3", regs_a[127:96], 32'h0);
        chk("rstmid_regs_reg1", regs_a[63:32], 32'h0);

        // paddr changed mid-ACCESS
        paddr = 32'h04; pwrite = 1'b0; pwdata = 32'h0;
        psel_a = 1'b1; penable_a = 1'b0;
        @(posedge clk); #1;
        penable_a = 1'b1;
        paddr = 32'h08;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pchg_pready", 32'(pready_a), 32'h1);
        @(posedge clk); #1;
        psel_a = 1'b0; penable_a = 1'b0;
        @(negedge clk);
        chk("pchg_proto", 32'(proto_a), PE);
        @(posedge clk); #1;
        xfer(0, 32'h1C, 1'b0, 32'h0, t_rd, t_err, t_cyc);
        chk("pchg_proto_sticky", 32'(proto_a), PE);
        chk("pchg_after_err",    32'(t_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
